// File: rtl/nf_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble insertion,
// flush and valid/ready back-pressure. Feeds srcA/srcB/shift/ALU_Code straight to the ALU.
module nf_ex_operand_stage #(
    parameter int FWD_EN      = 1,
    parameter int LU_STALL_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic        id_srcB_sel,
    input  logic        id_shamt_sel,
    input  logic [3:0]  id_ALU_Code,
    input  logic        id_we_rf,
    input  logic        id_is_load,
    input  logic        mem_we_rf,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_result,
    input  logic        wb_we_rf,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_result,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] srcA,
    output logic [31:0] srcB,
    output logic [31:0] shift,
    output logic [3:0]  ALU_Code,
    output logic [31:0] ex_rs2_data,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_we_rf,
    output logic        ex_is_load
);

    // MEM result wins over WB; x0 is hard-wired and never takes a bypass value.
    function automatic logic [31:0] fwd(
        input logic [4:0]  addr,
        input logic [31:0] raw,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_res,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_res
    );
        if (FWD_EN != 0 && addr != 5'd0 && m_we && m_rd == addr)
            return m_res;
        if (FWD_EN != 0 && addr != 5'd0 && w_we && w_rd == addr)
            return w_res;
        return raw;
    endfunction

    logic        vld_p1;
    logic [4:0]  rs1_addr_p1;
    logic [4:0]  rs2_addr_p1;
    logic [4:0]  rd_addr_p1;
    logic [31:0] rs1_data_p1;
    logic [31:0] rs2_data_p1;
    logic [31:0] imm_p1;
    logic        srcb_sel_p1;
    logic        shamt_sel_p1;
    logic [3:0]  alu_code_p1;
    logic        we_rf_p1;
    logic        is_load_p1;

    logic        load_use;
    logic        advance;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic [4:0]  shamt_bits;

    assign load_use = (LU_STALL_EN != 0) && vld_p1 && is_load_p1 && (rd_addr_p1 != 5'd0) &&
                      ((rd_addr_p1 == id_rs1_addr) || (rd_addr_p1 == id_rs2_addr));
    assign advance  = !vld_p1 || ex_ready;
    assign id_ready = !rst && !flush && !load_use && advance;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            rs1_addr_p1  <= '0;
            rs2_addr_p1  <= '0;
            rd_addr_p1   <= '0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            imm_p1       <= '0;
            srcb_sel_p1  <= 1'b0;
            shamt_sel_p1 <= 1'b0;
            alu_code_p1  <= '0;
            we_rf_p1     <= 1'b0;
            is_load_p1   <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= id_valid && !load_use;
            if (id_valid && !load_use) begin
                rs1_addr_p1  <= id_rs1_addr;
                rs2_addr_p1  <= id_rs2_addr;
                rd_addr_p1   <= id_rd_addr;
                rs1_data_p1  <= fwd(id_rs1_addr, id_rd1, mem_we_rf, mem_rd_addr, mem_result,
                                    wb_we_rf, wb_rd_addr, wb_result);
                rs2_data_p1  <= fwd(id_rs2_addr, id_rd2, mem_we_rf, mem_rd_addr, mem_result,
                                    wb_we_rf, wb_rd_addr, wb_result);
                imm_p1       <= id_imm;
                srcb_sel_p1  <= id_srcB_sel;
                shamt_sel_p1 <= id_shamt_sel;
                alu_code_p1  <= id_ALU_Code;
                we_rf_p1     <= id_we_rf;
                is_load_p1   <= id_is_load;
            end
        end else begin
            // Stalled: keep absorbing bypass values so a write retiring from WB is not lost.
            rs1_data_p1 <= rs1_fwd;
            rs2_data_p1 <= rs2_fwd;
        end
    end

    // ---- EX operand drive ----
    assign rs1_fwd = fwd(rs1_addr_p1, rs1_data_p1, mem_we_rf, mem_rd_addr, mem_result,
                         wb_we_rf, wb_rd_addr, wb_result);
    assign rs2_fwd = fwd(rs2_addr_p1, rs2_data_p1, mem_we_rf, mem_rd_addr, mem_result,
                         wb_we_rf, wb_rd_addr, wb_result);

    assign shamt_bits  = shamt_sel_p1 ? imm_p1[4:0] : rs2_fwd[4:0];
    assign srcA        = rs1_fwd;
    assign srcB        = srcb_sel_p1 ? imm_p1 : rs2_fwd;
    assign shift       = {27'b0, shamt_bits};
    assign ex_rs2_data = rs2_fwd;
    assign ex_valid    = vld_p1;
    assign ALU_Code    = vld_p1 ? alu_code_p1 : 4'd0;
    assign ex_rd_addr  = rd_addr_p1;
    assign ex_we_rf    = vld_p1 && we_rf_p1;
    assign ex_is_load  = vld_p1 && is_load_p1;

endmodule
